// File: rtl/time_unit_counter.sv
// rtl/time_unit_counter.sv - modulo-N time-unit counter stage (seconds/minutes/hours)
// Optional feature macro: TUC_COUNT_DOWN_EN adds the 'down' input for borrow-counting.
module time_unit_counter #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int FAST_DIV     = 60,
  parameter int MODULO       = 60,
  parameter int WIDTH        = 6,
  parameter int USE_EXT_TICK = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ext_tick,
  input  logic             run,
  input  logic             speed,
`ifdef TUC_COUNT_DOWN_EN
  input  logic             down,
`endif
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             carry_out,
  output logic             tick_out
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]    NORM_M1 = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0]    FAST_M1 = PW'((CLK_HZ / FAST_DIV) - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  logic [PW-1:0]    presc_q, presc_d;
  logic             speed_q, speed_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             carry_q, carry_d;
  logic             tick_out_q, tick_out_d;
  logic             tick_int;
  logic             tick;
  logic [PW-1:0]    period_m1;

  // Prescaler: free-running regardless of run; a speed change restarts the period without a tick.
  always_comb begin
    speed_d   = speed;
    period_m1 = speed ? FAST_M1 : NORM_M1;
    tick_int  = 1'b0;
    presc_d   = presc_q;
    if (USE_EXT_TICK != 0) begin
      presc_d = '0;
    end else if (speed != speed_q) begin
      presc_d = '0;
    end else if (presc_q >= period_m1) begin
      presc_d  = '0;
      tick_int = 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
    tick       = (USE_EXT_TICK != 0) ? ext_tick : tick_int;
    tick_out_d = tick;
  end

  // Count on tick while running; while stopped, a non-zero load_val loads with clamp to MODULO-1.
  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (run) begin
      if (tick) begin
`ifdef TUC_COUNT_DOWN_EN
        if (down) begin
          if (value_q == '0) begin
            value_d = MAX_VAL;
            carry_d = 1'b1;
          end else if (value_q > MAX_VAL) begin
            value_d = '0;
            carry_d = 1'b1;
          end else begin
            value_d = value_q - 1'b1;
          end
        end else
`endif
        if (value_q >= MAX_VAL) begin
          value_d = '0;
          carry_d = 1'b1;
        end else begin
          value_d = value_q + 1'b1;
        end
      end
    end else if (load_val != '0) begin
      value_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end
  end

  // State registers; reset discards any partial prescaler period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q    <= '0;
      speed_q    <= 1'b0;
      value_q    <= '0;
      carry_q    <= 1'b0;
      tick_out_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      speed_q    <= speed_d;
      value_q    <= value_d;
      carry_q    <= carry_d;
      tick_out_q <= tick_out_d;
    end
  end

  assign value     = value_q;
  assign carry_out = carry_q;
  assign tick_out  = tick_out_q;

endmodule

// File: tb/tb_time_unit_counter.sv
// tb/tb_time_unit_counter.sv - directed self-checking bench for time_unit_counter with a cascaded stage
module tb_time_unit_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       speed = 1'b0;
  logic [5:0] load_val = 6'd0;
  logic [5:0] a_value, b_value;
  logic       a_carry, b_carry, a_tick_out, b_tick_out;
  logic       b_run = 1'b1;
  logic       b_speed = 1'b0;
  logic [5:0] b_load = 6'd0;
`ifdef TUC_COUNT_DOWN_EN
  logic       down = 1'b0;
  logic       b_down = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  time_unit_counter #(.CLK_HZ(10), .FAST_DIV(5), .MODULO(60), .WIDTH(6), .USE_EXT_TICK(0)) u_a (
    .clk(clk), .reset(reset), .ext_tick(1'b0), .run(run), .speed(speed),
`ifdef TUC_COUNT_DOWN_EN
    .down(down),
`endif
    .load_val(load_val), .value(a_value), .carry_out(a_carry), .tick_out(a_tick_out)
  );

  time_unit_counter #(.CLK_HZ(10), .FAST_DIV(5), .MODULO(60), .WIDTH(6), .USE_EXT_TICK(1)) u_b (
    .clk(clk), .reset(reset), .ext_tick(a_carry), .run(b_run), .speed(b_speed),
`ifdef TUC_COUNT_DOWN_EN
    .down(b_down),
`endif
    .load_val(b_load), .value(b_value), .carry_out(b_carry), .tick_out(b_tick_out)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic test_reset_and_count();
    int ticks;
    int carries;
    ticks = 0;
    carries = 0;
    run = 1'b1; speed = 1'b0; load_val = 6'd0;
    apply_reset();
    checks++;
    if (a_value !== 6'd0 || a_carry !== 1'b0 || a_tick_out !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got value=%0d carry=%b tick=%b exp 0/0/0", a_value, a_carry, a_tick_out);
    end
    for (int i = 1; i <= 100; i++) begin
      step(1);
      if (a_tick_out === 1'b1) ticks++;
      if (a_carry === 1'b1) carries++;
      if (i == 9) begin
        checks++;
        if (a_value !== 6'd0) begin failures++; $display("FAIL t1_before_first_tick got=%0d exp=0", a_value); end
      end
      if (i == 10) begin
        checks++;
        if (a_value !== 6'd1) begin failures++; $display("FAIL t1_first_tick got=%0d exp=1", a_value); end
      end
    end
    checks++;
    if (a_value !== 6'd10) begin failures++; $display("FAIL t1_value_100clk got=%0d exp=10", a_value); end
    checks++;
    if (ticks != 10) begin failures++; $display("FAIL t1_tick_out_count got=%0d exp=10", ticks); end
    checks++;
    if (carries != 0) begin failures++; $display("FAIL t1_no_carry got=%0d exp=0", carries); end
  endtask

  task automatic test_wrap();
    int carries;
    carries = 0;
    run = 1'b1; speed = 1'b0; load_val = 6'd0;
    apply_reset();
    for (int i = 1; i <= 601; i++) begin
      step(1);
      if (a_carry === 1'b1) begin
        carries++;
        checks++;
        if (i != 600 || a_value !== 6'd0) begin
          failures++;
          $display("FAIL t2_carry_align got cycle=%0d value=%0d exp cycle=600 value=0", i, a_value);
        end
      end
      if (i == 599) begin
        checks++;
        if (a_value !== 6'd59) begin failures++; $display("FAIL t2_value_59 got=%0d exp=59", a_value); end
      end
      if (i == 601) begin
        checks++;
        if (b_value !== 6'd1 || b_tick_out !== 1'b1) begin
          failures++;
          $display("FAIL t2_stage_b got value=%0d tick=%b exp 1/1", b_value, b_tick_out);
        end
      end
    end
    checks++;
    if (carries != 1) begin failures++; $display("FAIL t2_carry_count got=%0d exp=1", carries); end
  endtask

  task automatic test_speed();
    run = 1'b1; speed = 1'b0; load_val = 6'd0;
    apply_reset();
    step(4);
    speed = 1'b1;
    step(2);
    checks++;
    if (a_value !== 6'd0) begin failures++; $display("FAIL t3_no_early_tick got=%0d exp=0", a_value); end
    step(1);
    checks++;
    if (a_value !== 6'd1 || a_tick_out !== 1'b1) begin
      failures++;
      $display("FAIL t3_first_fast_tick got value=%0d tick=%b exp 1/1", a_value, a_tick_out);
    end
    step(4);
    checks++;
    if (a_value !== 6'd3) begin failures++; $display("FAIL t3_fast_rate got=%0d exp=3", a_value); end
    step(1);
    speed = 1'b0;
    step(10);
    checks++;
    if (a_value !== 6'd3) begin failures++; $display("FAIL t3_toggle_suppress got=%0d exp=3", a_value); end
    step(1);
    checks++;
    if (a_value !== 6'd4) begin failures++; $display("FAIL t3_slow_restart got=%0d exp=4", a_value); end
  endtask

  task automatic test_load();
    int ticks;
    int carries;
    bit seen;
    ticks = 0;
    carries = 0;
    seen = 1'b0;
    run = 1'b0;
    load_val = 6'd45;
    step(1);
    checks++;
    if (a_value !== 6'd45) begin failures++; $display("FAIL t4_load_45 got=%0d exp=45", a_value); end
    load_val = 6'd63;
    step(1);
    checks++;
    if (a_value !== 6'd59) begin failures++; $display("FAIL t4_load_clamp got=%0d exp=59", a_value); end
    load_val = 6'd0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (a_tick_out === 1'b1) ticks++;
      if (a_carry === 1'b1) carries++;
    end
    checks++;
    if (a_value !== 6'd59) begin failures++; $display("FAIL t4_hold got=%0d exp=59", a_value); end
    checks++;
    if (ticks < 1 || carries != 0) begin
      failures++;
      $display("FAIL t4_stopped_ticks got ticks=%0d carries=%0d exp ticks>=1 carries=0", ticks, carries);
    end
    run = 1'b1;
    for (int i = 0; i < 12 && !seen; i++) begin
      step(1);
      if (a_carry === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen || a_value !== 6'd0) begin
      failures++;
      $display("FAIL t4_wrap_from_59 got seen=%0d value=%0d exp 1/0", seen, a_value);
    end
  endtask

  task automatic test_async_reset();
    run = 1'b0; speed = 1'b0; load_val = 6'd0;
    apply_reset();
    load_val = 6'd37;
    step(1);
    load_val = 6'd0;
    run = 1'b1;
    step(3);
    checks++;
    if (a_value !== 6'd37) begin failures++; $display("FAIL t5_preload got=%0d exp=37", a_value); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (a_value !== 6'd0 || a_carry !== 1'b0 || a_tick_out !== 1'b0) begin
      failures++;
      $display("FAIL t5_async_reset got value=%0d carry=%b tick=%b exp 0/0/0", a_value, a_carry, a_tick_out);
    end
    step(2);
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 9) begin
        checks++;
        if (a_value !== 6'd0) begin failures++; $display("FAIL t5_partial_discard got=%0d exp=0", a_value); end
      end
    end
    checks++;
    if (a_value !== 6'd1) begin failures++; $display("FAIL t5_first_tick got=%0d exp=1", a_value); end
  endtask

  task automatic test_cascade();
    int b_carries;
    b_carries = 0;
    run = 1'b1; speed = 1'b0; load_val = 6'd0;
    apply_reset();
    for (int i = 1; i <= 1201; i++) begin
      step(1);
      if (b_carry === 1'b1) b_carries++;
      if (i == 600 || i == 601 || i == 1200 || i == 1201) begin
        checks++;
        if (b_value !== ((i < 601) ? 6'd0 : (i < 1201) ? 6'd1 : 6'd2)) begin
          failures++;
          $display("FAIL t6_cascade_at_%0d got=%0d", i, b_value);
        end
      end
    end
    checks++;
    if (b_carries != 0) begin failures++; $display("FAIL t6_b_no_carry got=%0d exp=0", b_carries); end
  endtask

`ifdef TUC_COUNT_DOWN_EN
  task automatic test_count_down();
    run = 1'b1; speed = 1'b0; load_val = 6'd0; down = 1'b1;
    apply_reset();
    step(10);
    checks++;
    if (a_value !== 6'd59 || a_carry !== 1'b1) begin
      failures++;
      $display("FAIL t6_borrow got value=%0d carry=%b exp 59/1", a_value, a_carry);
    end
    step(10);
    checks++;
    if (a_value !== 6'd58 || a_carry !== 1'b0) begin
      failures++;
      $display("FAIL t6_down_step got value=%0d carry=%b exp 58/0", a_value, a_carry);
    end
    down = 1'b0;
  endtask
`endif

  initial begin
    test_reset_and_count();
    test_wrap();
    test_speed();
    test_load();
    test_async_reset();
    test_cascade();
`ifdef TUC_COUNT_DOWN_EN
    test_count_down();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
